datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Control FSM that fetches, decodes and sequences each 16-bit instruction through the RISC
//  datapath. It drives all datapath control inputs, the PC unit and the RAM command bus.
//  It consumes the instruction register value and the datapath status flags.
//  Sits between the instruction register / PC / RAM and the datapath in the CPU top level.
// PARAMETERS
//  IW        16  instruction width (fixed encoding; only 16 supported)
//  MEM_WAIT  1   1: hold in memory states until mem_rdy; 0: ignore mem_rdy (1-cycle RAM)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  instr      in   16  instruction register contents
//  status     in   3   datapath status {V,N,Z}
//  mem_rdy    in   1   RAM access complete this cycle
//  load_ir    out  1   capture mdata into instruction register
//  load_pc    out  1   PC load enable
//  pc_sel     out  2   00 reset(0), 01 PC+1, 10 PC+1+sximm8, 11 LR
//  addr_sel   out  1   1: RAM addr = PC; 0: RAM addr = data address register
//  load_addr  out  1   capture datapath_out[8:0] into data address register
//  mem_cmd    out  2   00 none, 01 read, 10 write
//  readnum, writenum  out 3  register file indices
//  write, loada, loadb, loadc, loads, asel, bsel  out 1  datapath enables/selects
//  vsel       out  2   00 C, 01 PC+1, 10 sximm8, 11 mdata
//  shift, ALUop  out 2  shifter op / ALU op (00 ADD, 01 SUB, 10 AND, 11 NOT B)
//  opcode     out  3   instr[15:13], passed through to shifter
//  sximm5, sximm8  out 16  sign-extended instr[4:0] / instr[7:0] (combinational)
//  halted     out  1   high in HALT state
// BEHAVIOUR
//  Fields: op=instr[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0].
//  Reset (rst_n low, async): state=RST, all enables 0, mem_cmd=00, halted=0.
//  RST: load_pc=1, pc_sel=00 -> IF1.  IF1: addr_sel=1, mem_cmd=01 -> IF2.
//  IF2: mem_cmd=01, load_ir=1 when mem_rdy, then -> UPD; without mem_rdy, stay in IF2.
//  UPD: load_pc=1, pc_sel=01 -> DEC.
//  DEC dispatch on opcode:
//   110/10 MOV Rn,#i8: WR: writenum=Rn, vsel=10, write=1 -> IF1 (4 states after fetch).
//   110/00 MOV Rd,Rm{sh}: GETB(readnum=Rm, loadb) -> EXE(asel=1, ALUop=00, loadc)
//     -> WR(writenum=Rd, vsel=00, write).
//   101 ALU: GETA(readnum=Rn, loada) -> GETB -> EXE(ALUop=op, loadc; loads=1 only for op=01 CMP).
//     CMP skips WR and goes to IF1. ADD/AND/MVN -> WR(Rd).
//   011 LDR: GETA(Rn) -> EXE(bsel=1, ALUop=00, loadc) -> ADDR(load_addr) -> MRD(addr_sel=0,
//     mem_cmd=01, hold till mem_rdy) -> WR(writenum=Rd, vsel=11).
//   100 STR: GETA(Rn) -> EXE(bsel) -> ADDR -> GETD(readnum=Rd, loadb)
//     -> MOVD(asel=1, shift=00, loadc) -> MWR(addr_sel=0, mem_cmd=10, hold till mem_rdy) -> IF1.
//   111: HALT; halted=1, all outputs idle; exit only by rst_n.
//   Any other opcode/op: -> IF1 (NOP, no register or flag write).
//  Control outputs are Moore (registered-state decode), held only in the state they are listed.
//  Unlisted outputs are 0 in every state.
//  mem_cmd stays constant throughout a hold state; the FSM never drops a command before mem_rdy.
//  MEM_WAIT=0: hold states always advance after 1 cycle.
//  rst_n low in any state, including a mid-memory hold: immediate RST, mem_cmd=00, no write.
// CONFIGURATION
//  SEQ_BRANCH_EN defined:
//   opcode 001 is a branch; cond=Rn: 000 B, 001 Z, 010 !Z, 011 N!=V, 100 (N!=V)|Z.
//   Taken: BR state, load_pc=1, pc_sel=10 -> IF1. Not taken: -> IF1.
//   010/11 BL: R7 <- PC+1 (writenum=7, vsel=01, write), then pc_sel=10.
//   010/00 BX: GETA(Rd), then load_pc with pc_sel=11.
//  SEQ_BRANCH_EN undefined: opcodes 001/010 are NOPs; pc_sel never takes 10/11.
// TESTING
//  rst_n pulse mid-MRD with mem_rdy=0 -> next edge state RST, mem_cmd=00; then load_pc with pc_sel=00.
//  MOV R0,#-3 (0xD0FD) -> WR cycle: writenum=0, vsel=10, write=1, sximm8=16'hFFFD.
//  CMP R1,R2 (0xA902) -> loads=1 for exactly 1 cycle, write never asserted, back to IF1.
//  LDR R3,[R1,#2] with mem_rdy delayed 3 cycles -> MRD held 4 cycles, mem_cmd=01;
//    then writenum=3, vsel=11.
//  HALT (0xE000) -> halted=1 and outputs stable for 100 cycles.
//  SEQ_BRANCH_EN: BEQ (0x2105) with status=001 -> pc_sel=10; with status=000 -> no load_pc.

Source files
------------

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - fetch/decode/execute control FSM for the 16-bit RISC datapath; SEQ_BRANCH_EN adds B/BL/BX
module datapath_sequencer #(
    parameter int IW       = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] instr,
    input  logic [2:0]    status,
    input  logic          mem_rdy,
    output logic          load_ir,
    output logic          load_pc,
    output logic [1:0]    pc_sel,
    output logic          addr_sel,
    output logic          load_addr,
    output logic [1:0]    mem_cmd,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    vsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [2:0]    opcode,
    output logic [15:0]   sximm5,
    output logic [15:0]   sximm8,
    output logic          halted
);

    localparam logic [2:0] OPC_B    = 3'b001;
    localparam logic [2:0] OPC_BL   = 3'b010;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD, S_DEC,
        S_GETA, S_GETB, S_EXE, S_WR,
        S_ADDR, S_MRD, S_GETD, S_MOVD, S_MWR,
        S_HALT, S_BR, S_BLWR, S_BX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0] w_opc;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic       w_mem_done;

    assign w_opc = instr[15:13];
    assign w_op  = instr[12:11];
    assign w_rn  = instr[10:8];
    assign w_rd  = instr[7:5];
    assign w_sh  = instr[4:3];
    assign w_rm  = instr[2:0];

    assign opcode = w_opc;
    assign sximm5 = {{11{instr[4]}}, instr[4:0]};
    assign sximm8 = {{8{instr[7]}}, instr[7:0]};

    // With a single-cycle RAM the hold states never wait for mem_rdy
    assign w_mem_done = (MEM_WAIT != 0) ? mem_rdy : 1'b1;

`ifdef SEQ_BRANCH_EN
    logic w_v, w_n, w_z;
    logic w_take;
    assign {w_v, w_n, w_z} = status;

    // Branch condition, selected by the Rn field
    always_comb begin
        w_take = 1'b0;
        case (w_rn)
            3'b000:  w_take = 1'b1;
            3'b001:  w_take = w_z;
            3'b010:  w_take = ~w_z;
            3'b011:  w_take = (w_n != w_v);
            3'b100:  w_take = (w_n != w_v) | w_z;
            default: w_take = 1'b0;
        endcase
    end
`else
    logic w_unused_status;
    assign w_unused_status = ^status;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RST;
        else        r_state <= w_next;
    end

    // Next-state decode; instr is stable from DEC until the next IF2
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST: w_next = S_IF1;
            S_IF1: w_next = S_IF2;
            S_IF2: if (w_mem_done) w_next = S_UPD;
            S_UPD: w_next = S_DEC;
            S_DEC: begin
                w_next = S_IF1;
                case (w_opc)
                    OPC_MOV: begin
                        if (w_op == 2'b10)      w_next = S_WR;
                        else if (w_op == 2'b00) w_next = S_GETB;
                    end
                    OPC_ALU, OPC_LDR, OPC_STR: w_next = S_GETA;
                    OPC_HALT: w_next = S_HALT;
`ifdef SEQ_BRANCH_EN
                    OPC_B: if (w_take) w_next = S_BR;
                    OPC_BL: begin
                        if (w_op == 2'b11)      w_next = S_BLWR;
                        else if (w_op == 2'b00) w_next = S_GETA;
                    end
`endif
                    default: w_next = S_IF1;
                endcase
            end
            S_GETA: begin
                w_next = S_EXE;
                if (w_opc == OPC_ALU) w_next = S_GETB;
`ifdef SEQ_BRANCH_EN
                if (w_opc == OPC_BL)  w_next = S_BX;
`endif
            end
            S_GETB: w_next = S_EXE;
            S_EXE: begin
                if (w_opc == OPC_LDR || w_opc == OPC_STR)      w_next = S_ADDR;
                else if (w_opc == OPC_ALU && w_op == 2'b01)    w_next = S_IF1;
                else                                           w_next = S_WR;
            end
            S_WR:   w_next = S_IF1;
            S_ADDR: w_next = (w_opc == OPC_LDR) ? S_MRD : S_GETD;
            S_MRD:  if (w_mem_done) w_next = S_WR;
            S_GETD: w_next = S_MOVD;
            S_MOVD: w_next = S_MWR;
            S_MWR:  if (w_mem_done) w_next = S_IF1;
            S_HALT: w_next = S_HALT;
            S_BR:   w_next = S_IF1;
            S_BLWR: w_next = S_BR;
            S_BX:   w_next = S_IF1;
            default: w_next = S_RST;
        endcase
    end

    // Moore output decode; everything is forced idle while rst_n is low
    always_comb begin
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        pc_sel    = 2'b00;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = CMD_NONE;
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = 2'b00;
        shift     = 2'b00;
        ALUop     = 2'b00;
        halted    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_RST: load_pc = 1'b1;
                S_IF1: begin
                    addr_sel = 1'b1;
                    mem_cmd  = CMD_READ;
                end
                // Address stays on PC for the whole fetch hold
                S_IF2: begin
                    addr_sel = 1'b1;
                    mem_cmd  = CMD_READ;
                    load_ir  = w_mem_done;
                end
                S_UPD: begin
                    load_pc = 1'b1;
                    pc_sel  = 2'b01;
                end
                S_GETA: begin
                    readnum = w_rn;
`ifdef SEQ_BRANCH_EN
                    if (w_opc == OPC_BL) readnum = w_rd;
`endif
                    loada = 1'b1;
                end
                S_GETB: begin
                    readnum = w_rm;
                    loadb   = 1'b1;
                end
                S_EXE: begin
                    loadc = 1'b1;
                    if (w_opc == OPC_LDR || w_opc == OPC_STR) begin
                        bsel = 1'b1;
                    end else if (w_opc == OPC_MOV) begin
                        asel  = 1'b1;
                        shift = w_sh;
                    end else begin
                        ALUop = w_op;
                        shift = w_sh;
                        loads = (w_op == 2'b01);
                    end
                end
                S_WR: begin
                    write = 1'b1;
                    if (w_opc == OPC_MOV && w_op == 2'b10) begin
                        writenum = w_rn;
                        vsel     = 2'b10;
                    end else if (w_opc == OPC_LDR) begin
                        writenum = w_rd;
                        vsel     = 2'b11;
                    end else begin
                        writenum = w_rd;
                        vsel     = 2'b00;
                    end
                end
                S_ADDR: load_addr = 1'b1;
                S_MRD:  mem_cmd   = CMD_READ;
                S_GETD: begin
                    readnum = w_rd;
                    loadb   = 1'b1;
                end
                S_MOVD: begin
                    asel  = 1'b1;
                    loadc = 1'b1;
                end
                S_MWR:  mem_cmd = CMD_WRITE;
                S_HALT: halted  = 1'b1;
                S_BR: begin
                    load_pc = 1'b1;
                    pc_sel  = 2'b10;
                end
                S_BLWR: begin
                    writenum = 3'd7;
                    vsel     = 2'b01;
                    write    = 1'b1;
                end
                S_BX: begin
                    load_pc = 1'b1;
                    pc_sel  = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - scoreboard bench for datapath_sequencer
module tb_datapath_sequencer;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] ALUop;
        logic       halted;
    } ctl_t;

    typedef struct packed {
        ctl_t        exp;
        logic        rdy;
        logic        rstn;
        logic        set_ir;
        logic [15:0] ir;
        logic [2:0]  st;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic [2:0]  status;
    logic        mem_rdy;
    logic        load_ir, load_pc, addr_sel, load_addr, write;
    logic        loada, loadb, loadc, loads, asel, bsel, halted;
    logic [1:0]  pc_sel, mem_cmd, vsel, shift, ALUop;
    logic [2:0]  readnum, writenum, opcode;
    logic [15:0] sximm5, sximm8;

    ctl_t  obs;
    rec_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    step   = 0;
    string tag    = "reset";

    datapath_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .status(status), .mem_rdy(mem_rdy),
        .load_ir(load_ir), .load_pc(load_pc), .pc_sel(pc_sel), .addr_sel(addr_sel),
        .load_addr(load_addr), .mem_cmd(mem_cmd), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .opcode(opcode), .sximm5(sximm5), .sximm8(sximm8), .halted(halted)
    );

    assign obs = {load_ir, load_pc, pc_sel, addr_sel, load_addr, mem_cmd, readnum, writenum,
                  write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input ctl_t e, input logic rdy, input logic rstn);
        rec_t r;
        r = '0;
        r.exp = e; r.rdy = rdy; r.rstn = rstn;
        sb.push_back(r);
    endtask

    task automatic put(input ctl_t e);
        push(e, 1'b0, 1'b1);
    endtask

    function automatic ctl_t c_rst();
        ctl_t e = '0;
        e.load_pc = 1'b1;
        return e;
    endfunction

    function automatic ctl_t c_geta(input logic [2:0] r);
        ctl_t e = '0;
        e.readnum = r; e.loada = 1'b1;
        return e;
    endfunction

    function automatic ctl_t c_getb(input logic [2:0] r);
        ctl_t e = '0;
        e.readnum = r; e.loadb = 1'b1;
        return e;
    endfunction

    function automatic ctl_t c_wr(input logic [2:0] w, input logic [1:0] v);
        ctl_t e = '0;
        e.writenum = w; e.vsel = v; e.write = 1'b1;
        return e;
    endfunction

    function automatic ctl_t c_pc(input logic [1:0] s);
        ctl_t e = '0;
        e.load_pc = 1'b1; e.pc_sel = s;
        return e;
    endfunction

    function automatic ctl_t c_mem(input logic [1:0] cmd);
        ctl_t e = '0;
        e.mem_cmd = cmd;
        return e;
    endfunction

    function automatic ctl_t c_exe(input logic [1:0] alu, input logic [1:0] sh,
                                   input logic a, input logic b, input logic s);
        ctl_t e = '0;
        e.loadc = 1'b1; e.ALUop = alu; e.shift = sh; e.asel = a; e.bsel = b; e.loads = s;
        return e;
    endfunction

    // IF1 (new instruction presented here), IF2 x (waits+1), UPD, DEC
    task automatic fetch(input logic [15:0] ir, input logic [2:0] st, input int waits);
        rec_t r;
        ctl_t e;
        r = '0;
        r.exp = '0; r.exp.addr_sel = 1'b1; r.exp.mem_cmd = 2'b01;
        r.rstn = 1'b1; r.set_ir = 1'b1; r.ir = ir; r.st = st;
        sb.push_back(r);
        e = '0; e.addr_sel = 1'b1; e.mem_cmd = 2'b01;
        for (int i = 0; i < waits; i++) push(e, 1'b0, 1'b1);
        e.load_ir = 1'b1;
        push(e, 1'b1, 1'b1);
        put(c_pc(2'b01));
        put('0);
    endtask

    task automatic drain();
        rec_t r;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk);
            rst_n   = r.rstn;
            mem_rdy = r.rdy;
            if (r.set_ir) begin
                instr  = r.ir;
                status = r.st;
            end
            #1;
            checks++;
            assert (obs === r.exp) else begin
                errors++;
                $error("FAIL %s step %0d observed %h expected %h", tag, step, obs, r.exp);
            end
            step++;
        end
    endtask

    task automatic check_val(input string t, input logic [15:0] o, input logic [15:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, o, x);
        end
    endtask

    initial begin
        ctl_t e;
        rst_n = 1'b0; mem_rdy = 1'b0; instr = 16'h0000; status = 3'b000;

        tag = "reset";
        push('0, 1'b0, 1'b0);
        push('0, 1'b1, 1'b0);
        push(c_rst(), 1'b0, 1'b1);
        drain();

        tag = "nop_fetch_wait";
        fetch(16'h0000, 3'b000, 2);
        drain();

        tag = "mov_imm";
        fetch(16'hD0FD, 3'b000, 0);
        put(c_wr(3'd0, 2'b10));
        drain();
        check_val("sximm8", sximm8, 16'hFFFD);
        check_val("sximm5", sximm5, 16'hFFFD);
        check_val("opcode", {13'd0, opcode}, 16'd6);

        tag = "add";
        fetch(16'hA162, 3'b000, 0);
        put(c_geta(3'd1)); put(c_getb(3'd2));
        put(c_exe(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
        put(c_wr(3'd3, 2'b00));
        drain();

        tag = "cmp";
        fetch(16'hA902, 3'b000, 0);
        put(c_geta(3'd1)); put(c_getb(3'd2));
        put(c_exe(2'b01, 2'b00, 1'b0, 1'b0, 1'b1));
        drain();

        tag = "mvn";
        fetch(16'hB8A2, 3'b000, 0);
        put(c_geta(3'd0)); put(c_getb(3'd2));
        put(c_exe(2'b11, 2'b00, 1'b0, 1'b0, 1'b0));
        put(c_wr(3'd5, 2'b00));
        drain();

        tag = "mov_reg";
        fetch(16'hC0AA, 3'b000, 0);
        put(c_getb(3'd2));
        put(c_exe(2'b00, 2'b01, 1'b1, 1'b0, 1'b0));
        put(c_wr(3'd5, 2'b00));
        drain();

        tag = "mov_bad_op";
        fetch(16'hC800, 3'b000, 0);
        drain();

        tag = "ldr";
        fetch(16'h6162, 3'b000, 0);
        put(c_geta(3'd1));
        put(c_exe(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        e = '0; e.load_addr = 1'b1; put(e);
        push(c_mem(2'b01), 1'b0, 1'b1);
        push(c_mem(2'b01), 1'b0, 1'b1);
        push(c_mem(2'b01), 1'b0, 1'b1);
        push(c_mem(2'b01), 1'b1, 1'b1);
        put(c_wr(3'd3, 2'b11));
        drain();

        tag = "str";
        fetch(16'h8162, 3'b000, 0);
        put(c_geta(3'd1));
        put(c_exe(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        e = '0; e.load_addr = 1'b1; put(e);
        put(c_getb(3'd3));
        e = '0; e.asel = 1'b1; e.loadc = 1'b1; put(e);
        push(c_mem(2'b10), 1'b0, 1'b1);
        push(c_mem(2'b10), 1'b1, 1'b1);
        drain();

        tag = "ldr_reset";
        fetch(16'h6162, 3'b000, 0);
        put(c_geta(3'd1));
        put(c_exe(2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
        e = '0; e.load_addr = 1'b1; put(e);
        push(c_mem(2'b01), 1'b0, 1'b1);
        push(c_mem(2'b01), 1'b0, 1'b1);
        push('0, 1'b0, 1'b0);
        push(c_rst(), 1'b0, 1'b1);
        drain();

        tag = "beq_taken";
        fetch(16'h2105, 3'b001, 0);
`ifdef SEQ_BRANCH_EN
        put(c_pc(2'b10));
`endif
        drain();

        tag = "beq_not_taken";
        fetch(16'h2105, 3'b000, 0);
        drain();

        tag = "bl";
        fetch(16'h5805, 3'b000, 0);
`ifdef SEQ_BRANCH_EN
        put(c_wr(3'd7, 2'b01));
        put(c_pc(2'b10));
`endif
        drain();

        tag = "bx";
        fetch(16'h40C0, 3'b000, 0);
`ifdef SEQ_BRANCH_EN
        put(c_geta(3'd6));
        put(c_pc(2'b11));
`endif
        drain();

        tag = "halt";
        fetch(16'hE000, 3'b000, 0);
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 100; i++) push(e, 1'($urandom_range(0, 1)), 1'b1);
        push('0, 1'b0, 1'b0);
        push(c_rst(), 1'b0, 1'b1);
        fetch(16'h0000, 3'b000, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
